// File: rtl/button_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module   : button_debounce_multi
// Purpose  : Multi-channel push-button conditioner. Each raw input passes
//            through a flop synchroniser and a stable-count debounce filter.
//            Every debounced edge produces a one-cycle press/release strobe.
//            Enabled edges set sticky pending bits that are cleared by
//            writing 1. All pending bits are OR-ed onto a single irq line.
// Ports    : clk           - system clock
//            rstn          - asynchronous active-low reset
//            button        - raw asynchronous inputs, one per channel
//            rise_en       - per channel: a press sets pending
//            fall_en       - per channel: a release sets pending
//            intr_clr      - write-1-to-clear for intr_pending
//            level         - debounced pressed state (1 = pressed)
//            press_pulse   - one-cycle strobe on each debounced 0->1
//            release_pulse - one-cycle strobe on each debounced 1->0
//            intr_pending  - sticky pending flags
//            irq           - OR of all pending flags
// Revision : 1.0 - initial release
// ============================================================================
module button_debounce_multi #(
    parameter int             NCH           = 4,
    parameter int             STABLE_CYCLES = 32,
    parameter int             SYNC_STAGES   = 2,
    parameter logic [NCH-1:0] INVERT        = {NCH{1'b0}}
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [NCH-1:0] button,
    input  logic [NCH-1:0] rise_en,
    input  logic [NCH-1:0] fall_en,
    input  logic [NCH-1:0] intr_clr,
    output logic [NCH-1:0] level,
    output logic [NCH-1:0] press_pulse,
    output logic [NCH-1:0] release_pulse,
    output logic [NCH-1:0] intr_pending,
    output logic           irq
);

    localparam int                 c_CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(STABLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic [NCH-1:0] w_sample;    // synchronised input, polarity-corrected
    logic [NCH-1:0] w_qualify;   // level toggles on this edge
    logic [NCH-1:0] r_level;
    logic [NCH-1:0] r_press;
    logic [NCH-1:0] r_release;
    logic [NCH-1:0] r_pending;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            logic [SYNC_STAGES-1:0] r_sync;
            logic [c_CNT_W-1:0]     r_cnt;
            logic                   w_differs;

            // Synchroniser resets to the inactive raw value so that leaving
            // reset with an idle button never looks like an edge.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_sync <= {SYNC_STAGES{INVERT[gi]}};
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], button[gi]};
                end
            end

            assign w_sample[gi]  = r_sync[SYNC_STAGES-1] ^ INVERT[gi];
            assign w_differs     = w_sample[gi] != r_level[gi];
            assign w_qualify[gi] = w_differs && (r_cnt == c_CNT_LAST);

            // Counts consecutive samples that disagree with the debounced
            // level; any agreeing sample (a bounce back) restarts the filter.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_cnt <= '0;
                end else if (!w_differs || w_qualify[gi]) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                end
            end
        end
    endgenerate

    // Strobes are registered on the same edge as the level change, so a
    // qualifying channel flips its level and raises exactly one strobe.
    // Pending is fed from the registered strobes and therefore sets one
    // cycle later; a set on the same edge as a clear wins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_level   <= '0;
            r_press   <= '0;
            r_release <= '0;
            r_pending <= '0;
        end else begin
            r_level   <= r_level ^ w_qualify;
            r_press   <= w_qualify & w_sample;
            r_release <= w_qualify & ~w_sample;
            r_pending <= (r_pending & ~intr_clr)
                       | (r_press & rise_en)
                       | (r_release & fall_en);
        end
    end

    assign level         = r_level;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign intr_pending  = r_pending;
    // Driven only from flops, so the OR cannot glitch on input activity.
    assign irq           = |r_pending;

endmodule
`default_nettype wire

// File: tb/tb_button_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_debounce_multi
// Purpose  : Self-checking bench for button_debounce_multi. Two instances
//            share all inputs: one with non-inverted inputs, one with
//            channel 1 active-low. A reference model predicts level, strobes
//            and pending bits; strobe events go through a scoreboard queue
//            that a separate monitor drains.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_debounce_multi;

    localparam int             NCH           = 4;
    localparam int             STABLE_CYCLES = 8;
    localparam int             SYNC_STAGES   = 2;
    localparam logic [NCH-1:0] INV0          = 4'b0000;
    localparam logic [NCH-1:0] INV1          = 4'b0010;

    logic           clk      = 1'b0;
    logic           rstn     = 1'b0;
    logic [NCH-1:0] button   = '0;
    logic [NCH-1:0] rise_en  = '0;
    logic [NCH-1:0] fall_en  = '0;
    logic [NCH-1:0] intr_clr = '0;

    logic [NCH-1:0] level_w [2];
    logic [NCH-1:0] pp_w    [2];
    logic [NCH-1:0] rp_w    [2];
    logic [NCH-1:0] pend_w  [2];
    logic           irq_w   [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    button_debounce_multi #(
        .NCH(NCH), .STABLE_CYCLES(STABLE_CYCLES), .SYNC_STAGES(SYNC_STAGES), .INVERT(INV0)
    ) u_dut0 (
        .clk(clk), .rstn(rstn), .button(button), .rise_en(rise_en), .fall_en(fall_en),
        .intr_clr(intr_clr), .level(level_w[0]), .press_pulse(pp_w[0]),
        .release_pulse(rp_w[0]), .intr_pending(pend_w[0]), .irq(irq_w[0])
    );

    button_debounce_multi #(
        .NCH(NCH), .STABLE_CYCLES(STABLE_CYCLES), .SYNC_STAGES(SYNC_STAGES), .INVERT(INV1)
    ) u_dut1 (
        .clk(clk), .rstn(rstn), .button(button), .rise_en(rise_en), .fall_en(fall_en),
        .intr_clr(intr_clr), .level(level_w[1]), .press_pulse(pp_w[1]),
        .release_pulse(rp_w[1]), .intr_pending(pend_w[1]), .irq(irq_w[1])
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: the level of a channel flips when the last
    // STABLE_CYCLES synchronised samples all disagree with it. Samples are
    // the raw input delayed by SYNC_STAGES edges.
    // ------------------------------------------------------------------
    typedef struct packed {
        int unsigned d;
        int unsigned ch;
        logic        rise;
    } ev_t;

    ev_t            expq [$];
    logic [NCH-1:0] m_level [2];
    logic [NCH-1:0] m_press [2];
    logic [NCH-1:0] m_rel   [2];
    logic [NCH-1:0] m_pend  [2];
    logic [NCH-1:0] rawh    [2][SYNC_STAGES];
    logic [NCH-1:0] smph    [2][STABLE_CYCLES];

    function automatic logic [NCH-1:0] inv_of(input int d);
        return (d == 0) ? INV0 : INV1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_level[d] = '0;
            m_press[d] = '0;
            m_rel[d]   = '0;
            m_pend[d]  = '0;
            for (int k = 0; k < SYNC_STAGES; k++) rawh[d][k] = '0;
            for (int k = 0; k < STABLE_CYCLES; k++) smph[d][k] = '0;
        end
        expq.delete();
    endtask

    task automatic model_step();
        logic [NCH-1:0] s;
        logic           all_diff;
        for (int d = 0; d < 2; d++) begin
            m_pend[d] = (m_pend[d] & ~intr_clr) | (m_press[d] & rise_en) | (m_rel[d] & fall_en);
            s = rawh[d][0];
            for (int k = 0; k < SYNC_STAGES - 1; k++) rawh[d][k] = rawh[d][k+1];
            rawh[d][SYNC_STAGES-1] = button ^ inv_of(d);
            for (int k = 0; k < STABLE_CYCLES - 1; k++) smph[d][k] = smph[d][k+1];
            smph[d][STABLE_CYCLES-1] = s;
            m_press[d] = '0;
            m_rel[d]   = '0;
            for (int c = 0; c < NCH; c++) begin
                all_diff = 1'b1;
                for (int k = 0; k < STABLE_CYCLES; k++)
                    if (smph[d][k][c] == m_level[d][c]) all_diff = 1'b0;
                if (all_diff) begin
                    m_level[d][c] = ~m_level[d][c];
                    if (m_level[d][c]) m_press[d][c] = 1'b1;
                    else               m_rel[d][c]   = 1'b1;
                    expq.push_back('{d: d, ch: c, rise: m_level[d][c]});
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) model_reset();
            else       model_step();
        end
    end

    // ------------------------------------------------------------------
    // Monitor: drains the scoreboard on each strobe and compares the
    // steady outputs against the model once per cycle.
    // ------------------------------------------------------------------
    initial begin
        ev_t ev;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < NCH; c++) begin
                    if (pp_w[d][c] || rp_w[d][c]) begin
                        chk("pulse_exclusive", longint'(pp_w[d][c] & rp_w[d][c]), 0);
                        if (expq.size() == 0) begin
                            chk("unexpected_pulse", d * 100 + c * 10 + int'(pp_w[d][c]), -1);
                        end else begin
                            ev = expq.pop_front();
                            chk("pulse_event", d * 100 + c * 10 + int'(pp_w[d][c]),
                                ev.d * 100 + ev.ch * 10 + int'(ev.rise));
                        end
                    end
                end
            end
            chk("missing_pulses", expq.size(), 0);
            expq.delete();
            for (int d = 0; d < 2; d++) begin
                chk("level",        level_w[d], m_level[d]);
                chk("intr_pending", pend_w[d],  m_pend[d]);
                chk("irq",          longint'(irq_w[d]), longint'(|m_pend[d]));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts rising edges until level_w[d][c] reaches val; -1 on timeout.
    task automatic wait_level(input int d, input int c, input logic val, output int lat);
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (level_w[d][c] == val) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int found;

        cyc(3);
        rstn = 1'b1;

        // Idle after reset
        cyc(20);
        chk("t1_level",   level_w[0], 0);
        chk("t1_pending", pend_w[0],  0);
        chk("t1_irq",     longint'(irq_w[0]), 0);

        // Single press, latency, pending and clear
        rise_en   = 4'b0001;
        button[0] = 1'b1;
        wait_level(0, 0, 1'b1, lat);
        chk("t2_press_latency", lat, SYNC_STAGES + STABLE_CYCLES);
        cyc(2);
        chk("t2_pending_set", longint'(pend_w[0][0]), 1);
        chk("t2_irq_set",     longint'(irq_w[0]), 1);
        intr_clr = 4'b0001;
        cyc(1);
        intr_clr = 4'b0000;
        chk("t2_pending_clr", longint'(pend_w[0][0]), 0);
        chk("t2_irq_clr",     longint'(irq_w[0]), 0);

        // Bounce restarts the filter
        button[1] = 1'b1;
        cyc(7);
        chk("t3_no_early_level", longint'(level_w[0][1]), 0);
        button[1] = 1'b0;
        cyc(1);
        button[1] = 1'b1;
        cyc(7);
        chk("t3_still_low", longint'(level_w[0][1]), 0);
        wait_level(0, 1, 1'b1, lat);
        chk("t3_bounce_latency", lat, 3);

        // Release with and without fall_en
        rise_en   = 4'b0000;
        fall_en   = 4'b0001;
        button[0] = 1'b0;
        cyc(14);
        chk("t4_release_pending", longint'(pend_w[0][0]), 1);
        intr_clr = 4'b0001;
        cyc(1);
        intr_clr  = 4'b0000;
        fall_en   = 4'b0000;
        button[0] = 1'b1;
        cyc(14);
        button[0] = 1'b0;
        cyc(14);
        chk("t4_release_masked", longint'(pend_w[0][0]), 0);

        // Set beats clear on the same edge; simultaneous channels
        intr_clr = 4'b1111;
        cyc(1);
        intr_clr  = 4'b0000;
        rise_en   = 4'b1111;
        button[2] = 1'b1;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (pp_w[0][2]) begin
                found = 1;
                break;
            end
        end
        chk("t5_pulse_seen", found, 1);
        intr_clr[2] = 1'b1;
        cyc(1);
        intr_clr[2] = 1'b0;
        chk("t5_set_beats_clear", longint'(pend_w[0][2]), 1);
        intr_clr = 4'b1111;
        cyc(1);
        intr_clr  = 4'b0000;
        button[0] = 1'b1;
        button[3] = 1'b1;
        cyc(14);
        chk("t5_pending_ch0", longint'(pend_w[0][0]), 1);
        chk("t5_pending_ch3", longint'(pend_w[0][3]), 1);

        // Active-low channel: idle-high is inactive; reset mid-count
        cyc(5);
        chk("t6_inv_idle_level", longint'(level_w[1][1]), 0);
        button[1] = 1'b0;
        cyc(SYNC_STAGES + 4);
        #2 rstn = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("t6_rst_level",   level_w[d], 0);
            chk("t6_rst_press",   pp_w[d],    0);
            chk("t6_rst_release", rp_w[d],    0);
            chk("t6_rst_pending", pend_w[d],  0);
            chk("t6_rst_irq",     longint'(irq_w[d]), 0);
        end
        cyc(3);
        rstn = 1'b1;
        wait_level(1, 1, 1'b1, lat);
        chk("t6_requalify_latency", lat, SYNC_STAGES + STABLE_CYCLES);

        // Randomised traffic with one asynchronous reset in the middle
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(0, 11) == 0) button[c] = ~button[c];
            intr_clr = NCH'($urandom & $urandom & $urandom);
            if (i % 50 == 0) begin
                rise_en = NCH'($urandom);
                fall_en = NCH'($urandom);
            end
            if (i == 700) #2 rstn = 1'b0;
            if (i == 703) rstn = 1'b1;
        end
        intr_clr = '0;
        cyc(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_debounce_multi.md
Name: button_debounce_multi

Overview:
Multi-channel successor to the single-button soft-interrupt block. It synchronises NCH raw push-button/switch inputs and debounces each with a parametrised stable-count filter. It generates one-cycle press/release pulses and keeps per-channel sticky interrupt-pending bits with write-1-to-clear. It sits between board pins and the interrupt controller, and drives a single aggregated irq line.

Parameters:
NCH, 4, number of independent button channels (>=1)
STABLE_CYCLES, 32, consecutive synchronised samples that must differ from the current debounced level before the level changes (>=1)
SYNC_STAGES, 2, flops in each input synchroniser (>=2)
INVERT, {NCH{1'b0}}, per-channel polarity; bit=1 means the raw input is active-low

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
button  input  NCH  raw asynchronous button inputs
rise_en  input  NCH  per-channel enable: a press sets pending
fall_en  input  NCH  per-channel enable: a release sets pending
intr_clr  input  NCH  write-1-to-clear for intr_pending, sampled each clk
level  output  NCH  debounced pressed state (1 = pressed)
press_pulse  output  NCH  one-cycle strobe on each debounced 0->1
release_pulse  output  NCH  one-cycle strobe on each debounced 1->0
intr_pending  output  NCH  sticky pending flags
irq  output  1  OR-reduction of intr_pending

Behaviour:
- Reset is asynchronous and active-low: clk, rstn; one clock domain only.
- Reset values: synchroniser flops = INVERT bit (the inactive raw value); counters 0; level, press_pulse, release_pulse, intr_pending = 0; irq = 0.
- Synchroniser: SYNC_STAGES-deep flop chain per channel. sample = sync_out XOR INVERT.
- Per-channel counter, width clog2(STABLE_CYCLES+1):
  - If sample == level: counter <= 0 (a bounce back restarts the filter).
  - Else if counter == STABLE_CYCLES-1: level <= sample; counter <= 0.
  - Else: counter <= counter+1.
- Latency: a raw change held steady is visible on level exactly SYNC_STAGES+STABLE_CYCLES rising edges after the first edge that samples it. A counter that reaches STABLE_CYCLES-1 but sees sample == level resets and does not toggle.
- STABLE_CYCLES=1: level follows sample with a 1-cycle delay.
- press_pulse / release_pulse are registered on the same edge as the level change they report. Each is high for exactly one cycle. A single channel never asserts both in the same cycle.
- intr_pending[i] <= (intr_pending[i] & ~intr_clr[i]) | (press_pulse[i] & rise_en[i]) | (release_pulse[i] & fall_en[i]).
  - Pending therefore sets one cycle after the pulse.
  - If set and clear occur on the same edge, set wins.
  - Clearing an already-clear bit has no effect.
- Toggling rise_en/fall_en never clears pending; the enables only gate new events.
- irq = |intr_pending; it is combinational from registers and glitch-free.
- Channels are fully independent; simultaneous events on any channel subset are all captured.
- Reset asserted mid-count: all state returns to reset values immediately. After release, a held button re-qualifies from counter 0 and produces a fresh press_pulse.
- No saturation or wrap concerns: the counter never exceeds STABLE_CYCLES-1.

Test Plan:
1. NCH=4, STABLE_CYCLES=8, SYNC_STAGES=2, INVERT=0. Apply reset, button=0 for 20 cycles -> level, pulses, pending, irq all 0.
2. Raise button[0] and hold it; rise_en[0]=1 -> level[0] rises exactly 10 edges later, press_pulse[0] is high for 1 cycle on that edge, intr_pending[0]=1 and irq=1 one cycle after. Pulse intr_clr[0] for one cycle -> pending[0]=0, irq=0.
3. Bounce on button[1]: high 7 cycles, low 1, then high 8 -> no change during the first 7 cycles. level[1] rises 10 edges after the final rise, with exactly one press_pulse.
4. Release on button[0] with fall_en[0]=1, rise_en[0]=0 -> release_pulse[0] on the level fall, pending set. Repeat with fall_en[0]=0 -> pulse occurs but pending stays 0.
5. Drive intr_clr[2]=1 on the same edge a new press_pulse[2] qualifies -> intr_pending[2] ends at 1. Press channels 0 and 3 in the same cycle -> both pending bits set.
6. INVERT=4'b0010 with button[1] idle-high -> no events. Drop button[1] mid-count (after 4 of 8 cycles), assert rstn=0 asynchronously -> outputs clear immediately. After release, the held-low button produces level[1]=1 after 10 edges.
